// File: rtl/fifo_ctrl_if.sv
// Handshake and RAM-port bundle for fifo_ctrl.
// master: the controller side; slave: the surrounding system (producer,
// consumer and the simple-dual-port RAM).
interface fifo_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
);
  logic             flush;
  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [WIDTH-1:0] rd_data;
  logic             ram_we;
  logic [AW-1:0]    ram_waddr;
  logic [WIDTH-1:0] ram_wdata;
  logic             ram_re;
  logic [AW-1:0]    ram_raddr;
  logic [WIDTH-1:0] ram_rdata;
  logic [AW+1:0]    level;
  logic             almost_full;
  logic             almost_empty;

  modport master (
    input  flush, wr_valid, wr_data, rd_ready, ram_rdata,
    output wr_ready, rd_valid, rd_data, ram_we, ram_waddr, ram_wdata,
           ram_re, ram_raddr, level, almost_full, almost_empty
  );

  modport slave (
    output flush, wr_valid, wr_data, rd_ready, ram_rdata,
    input  wr_ready, rd_valid, rd_data, ram_we, ram_waddr, ram_wdata,
           ram_re, ram_raddr, level, almost_full, almost_empty
  );
endinterface

// File: rtl/fifo_ctrl.sv
// FIFO controller: pointers and occupancy for an external 1-cycle-latency
// SDP RAM, plus a 2-entry prefetch buffer so the read port streams at one
// word per cycle. Fullness comes from ram_count only, never from pointers.
module fifo_ctrl #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AW       = $clog2(DEPTH),
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input logic        clk,
  input logic        rst_n,
  fifo_ctrl_if.master bus
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW+1:0] AF_C    = (AW+2)'(AF_LEVEL);
  localparam logic [AW+1:0] AE_C    = (AW+2)'(AE_LEVEL);

  logic [AW-1:0]    wptr_r, rptr_r;
  logic [AW:0]      ram_count_r, ram_count_nxt_s;
  logic             inflight_r;
  logic [1:0]       ob_count_r, ob_count_nxt_s, ob_keep_s;
  logic [WIDTH-1:0] ob0_r, ob1_r, ob0_nxt_s, ob1_nxt_s;
  logic [AW+1:0]    level_r, level_nxt_s;
  logic             rd_valid_r, af_r, ae_r;
  logic             wr_ready_s, wr_acc_s, pop_s, re_s;

  // Handshakes, read issue and next-state occupancy / buffer contents.
  always_comb begin
    wr_ready_s = !bus.flush && (ram_count_r < DEPTH_C);
    // rst_n gate keeps the RAM write port quiet while reset is held.
    wr_acc_s   = bus.wr_valid && wr_ready_s && rst_n;
    pop_s      = rd_valid_r && bus.rd_ready;
    // rd_valid implies ob_count_r > 0, so this cannot underflow.
    ob_keep_s  = ob_count_r - {1'b0, pop_s};
    // Issue only when the returning word is guaranteed a buffer slot.
    re_s       = !bus.flush && rst_n && (ram_count_r != {(AW+1){1'b0}}) &&
                 (({1'b0, ob_keep_s} + {2'b00, inflight_r}) < 3'd2);

    ram_count_nxt_s = ram_count_r + {{AW{1'b0}}, wr_acc_s} - {{AW{1'b0}}, re_s};

    ob0_nxt_s = ob0_r;
    ob1_nxt_s = ob1_r;
    if (pop_s) begin
      ob0_nxt_s = ob1_r;
    end else begin
      ob0_nxt_s = ob0_r;
    end
    // Returning RAM word lands in the first slot left free after the pop.
    if (inflight_r) begin
      if (ob_keep_s == 2'd0) begin
        ob0_nxt_s = bus.ram_rdata;
      end else begin
        ob1_nxt_s = bus.ram_rdata;
      end
    end else begin
      ob1_nxt_s = ob1_nxt_s;
    end
    ob_count_nxt_s = ob_keep_s + {1'b0, inflight_r};

    level_nxt_s = {1'b0, ram_count_nxt_s} + {{(AW+1){1'b0}}, re_s} +
                  {{AW{1'b0}}, ob_count_nxt_s};
  end

  // State and registered status; flush clears everything and drops any
  // RAM word returning in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r      <= {AW{1'b0}};
      rptr_r      <= {AW{1'b0}};
      ram_count_r <= {(AW+1){1'b0}};
      inflight_r  <= 1'b0;
      ob_count_r  <= 2'd0;
      ob0_r       <= {WIDTH{1'b0}};
      ob1_r       <= {WIDTH{1'b0}};
      level_r     <= {(AW+2){1'b0}};
      rd_valid_r  <= 1'b0;
      af_r        <= 1'b0;
      ae_r        <= 1'b1;
    end else if (bus.flush) begin
      wptr_r      <= {AW{1'b0}};
      rptr_r      <= {AW{1'b0}};
      ram_count_r <= {(AW+1){1'b0}};
      inflight_r  <= 1'b0;
      ob_count_r  <= 2'd0;
      ob0_r       <= {WIDTH{1'b0}};
      ob1_r       <= {WIDTH{1'b0}};
      level_r     <= {(AW+2){1'b0}};
      rd_valid_r  <= 1'b0;
      af_r        <= 1'b0;
      ae_r        <= 1'b1;
    end else begin
      wptr_r      <= wptr_r + {{(AW-1){1'b0}}, wr_acc_s};
      rptr_r      <= rptr_r + {{(AW-1){1'b0}}, re_s};
      ram_count_r <= ram_count_nxt_s;
      inflight_r  <= re_s;
      ob_count_r  <= ob_count_nxt_s;
      ob0_r       <= ob0_nxt_s;
      ob1_r       <= ob1_nxt_s;
      level_r     <= level_nxt_s;
      rd_valid_r  <= (ob_count_nxt_s != 2'd0);
      af_r        <= (level_nxt_s >= AF_C);
      ae_r        <= (level_nxt_s <= AE_C);
    end
  end

  assign bus.wr_ready     = wr_ready_s;
  assign bus.ram_we       = wr_acc_s;
  assign bus.ram_waddr    = wptr_r;
  assign bus.ram_wdata    = bus.wr_data;
  assign bus.ram_re       = re_s;
  assign bus.ram_raddr    = rptr_r;
  assign bus.rd_valid     = rd_valid_r;
  assign bus.rd_data      = ob0_r;
  assign bus.level        = level_r;
  assign bus.almost_full  = af_r;
  assign bus.almost_empty = ae_r;

endmodule
